// File: rtl/adj_control.sv
// adj_control: raster-derived enables plus a multi-channel debounced level-adjust engine.
// Define AUTOREPEAT_EN to enable hold-to-auto-repeat of the inc/dec keys.
module adj_control #(
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480,
  parameter int SHIFT_X     = 781,
  parameter int SHIFT_Y_MAX = 528,
  parameter int CNT_W       = 13,
  parameter int NUM_ADJ     = 4,
  parameter int LVL_W       = 8,
  parameter int LVL_LIM     = 127,
  parameter int STEP        = 4,
  parameter int DEB_CYC     = 16,
  parameter int REPEAT_DLY  = 25000000,
  parameter int REPEAT_RATE = 5000000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [9:0]                 SW,
  input  logic [3:0]                 KEY,
  input  logic [CNT_W-1:0]           row,
  input  logic [CNT_W-1:0]           col,
  input  logic [CNT_W-1:0]           x_count,
  input  logic [CNT_W-1:0]           y_count,
  output logic                       frame_en,
  output logic                       wr_en,
  output logic                       shift_en,
  output logic                       sel_valid,
  output logic [NUM_ADJ-1:0]         inc_pulse,
  output logic [NUM_ADJ-1:0]         dec_pulse,
  output logic [NUM_ADJ*LVL_W-1:0]   level_out
);

  localparam int IDX_W = (NUM_ADJ > 1) ? $clog2(NUM_ADJ) : 1;
  localparam int DEB_W = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
  localparam int RPT_W = 32;
`ifdef AUTOREPEAT_EN
  localparam bit AR_EN = 1'b1;
`else
  localparam bit AR_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, HOLD, REPEAT} state_e;

  logic unused_in;
  assign unused_in = ^{SW, KEY[3]};

  // Raster-derived enables
  logic match_d, match_q, frame_en_d, frame_en_q;
  logic wr_en_d, wr_en_q, shift_en_d, shift_en_q;

  always_comb begin
    match_d    = (row == CNT_W'(V_ACTIVE)) && (col == CNT_W'(H_ACTIVE));
    frame_en_d = match_d && !match_q;
    wr_en_d    = col < CNT_W'(H_ACTIVE);
    shift_en_d = (x_count == CNT_W'(SHIFT_X)) && (y_count < CNT_W'(SHIFT_Y_MAX));
  end

  // Key synchroniser and debounce (keys 0..2, active-high after inversion)
  logic [2:0]            sync1_q, sync2_q, pressed;
  logic [2:0]            deb_d, deb_q;
  logic [2:0][DEB_W-1:0] deb_cnt_d, deb_cnt_q;

  always_comb begin
    pressed   = ~sync2_q;
    deb_d     = deb_q;
    deb_cnt_d = '0;
    for (int unsigned k = 0; k < 3; k++) begin
      if (pressed[k] != deb_q[k]) begin
        if (deb_cnt_q[k] == DEB_W'(DEB_CYC - 1)) deb_d[k] = pressed[k];
        else deb_cnt_d[k] = deb_cnt_q[k] + 1'b1;
      end
    end
  end

  // Channel selection
  logic [3:0]       sel_cnt;
  logic [IDX_W-1:0] sel_idx_d, sel_idx_q;
  logic             sel_valid_d, sel_valid_q;

  always_comb begin
    sel_cnt   = '0;
    sel_idx_d = '0;
    for (int unsigned i = 0; i < NUM_ADJ; i++) begin
      if (SW[i+1]) begin
        sel_cnt   = sel_cnt + 1'b1;
        sel_idx_d = IDX_W'(i);
      end
    end
    sel_valid_d = (sel_cnt == 4'd1);
  end

  // Adjust FSM
  state_e           state_d, state_q;
  logic [RPT_W-1:0] rpt_cnt_d, rpt_cnt_q;
  logic [IDX_W-1:0] hold_idx_d, hold_idx_q;
  logic             dir_dec_d, dir_dec_q;
  logic             clr_prev_q;
  logic             inc_k, dec_k, both_k, held_k, sel_lost, ev, clr_now;

  always_comb begin
    state_d    = state_q;
    rpt_cnt_d  = rpt_cnt_q;
    hold_idx_d = hold_idx_q;
    dir_dec_d  = dir_dec_q;
    ev         = 1'b0;
    inc_k      = deb_q[0];
    dec_k      = deb_q[1];
    both_k     = inc_k && dec_k;
    held_k     = dir_dec_q ? dec_k : inc_k;
    sel_lost   = !sel_valid_q || (sel_idx_q != hold_idx_q);
    clr_now    = deb_q[2] && !clr_prev_q && sel_valid_q;
    case (state_q)
      IDLE: begin
        if ((inc_k ^ dec_k) && sel_valid_q) begin
          ev         = 1'b1;
          rpt_cnt_d  = '0;
          hold_idx_d = sel_idx_q;
          dir_dec_d  = dec_k;
          state_d    = HOLD;
        end
      end
      HOLD: begin
        if (!held_k || both_k || sel_lost) begin
          state_d   = IDLE;
          rpt_cnt_d = '0;
        end else if (AR_EN) begin
          if (rpt_cnt_q == RPT_W'(REPEAT_DLY - 1)) begin
            ev        = 1'b1;
            rpt_cnt_d = '0;
            state_d   = REPEAT;
          end else begin
            rpt_cnt_d = rpt_cnt_q + 1'b1;
          end
        end
      end
      REPEAT: begin
        if (!held_k || both_k || sel_lost) begin
          state_d   = IDLE;
          rpt_cnt_d = '0;
        end else if (rpt_cnt_q == RPT_W'(REPEAT_RATE - 1)) begin
          ev        = 1'b1;
          rpt_cnt_d = '0;
        end else begin
          rpt_cnt_d = rpt_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  function automatic logic signed [LVL_W-1:0] step_sat(input logic signed [LVL_W-1:0] cur,
                                                       input logic dn);
    logic signed [LVL_W:0] ext, stp, lim;
    ext = {cur[LVL_W-1], cur};
    stp = (LVL_W+1)'(STEP);
    lim = (LVL_W+1)'(LVL_LIM);
    ext = dn ? ext - stp : ext + stp;
    if (ext > lim) ext = lim;
    else if (ext < -lim) ext = -lim;
    return ext[LVL_W-1:0];
  endfunction

  // Working levels; a clear wins over a same-cycle event, which is then dropped
  logic signed [LVL_W-1:0] level_d [NUM_ADJ];
  logic signed [LVL_W-1:0] level_q [NUM_ADJ];
  logic signed [LVL_W-1:0] lvl_out_d [NUM_ADJ];
  logic signed [LVL_W-1:0] lvl_out_q [NUM_ADJ];
  logic [NUM_ADJ-1:0]      inc_pulse_d, inc_pulse_q, dec_pulse_d, dec_pulse_q;

  always_comb begin
    inc_pulse_d = '0;
    dec_pulse_d = '0;
    for (int unsigned i = 0; i < NUM_ADJ; i++) begin
      level_d[i]   = level_q[i];
      lvl_out_d[i] = frame_en_q ? level_q[i] : lvl_out_q[i];
    end
    if (clr_now) begin
      level_d[sel_idx_q] = '0;
    end else if (ev) begin
      if (dir_dec_d) dec_pulse_d[sel_idx_q] = 1'b1;
      else inc_pulse_d[sel_idx_q] = 1'b1;
      level_d[sel_idx_q] = step_sat(level_q[sel_idx_q], dir_dec_d);
    end
  end

  always_comb begin
    level_out = '0;
    for (int unsigned i = 0; i < NUM_ADJ; i++) level_out[i*LVL_W +: LVL_W] = lvl_out_q[i];
  end

  assign frame_en  = frame_en_q;
  assign wr_en     = wr_en_q;
  assign shift_en  = shift_en_q;
  assign sel_valid = sel_valid_q;
  assign inc_pulse = inc_pulse_q;
  assign dec_pulse = dec_pulse_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      match_q     <= 1'b0;
      frame_en_q  <= 1'b0;
      wr_en_q     <= 1'b0;
      shift_en_q  <= 1'b0;
      sync1_q     <= '1;
      sync2_q     <= '1;
      deb_q       <= '0;
      deb_cnt_q   <= '0;
      sel_idx_q   <= '0;
      sel_valid_q <= 1'b0;
      state_q     <= IDLE;
      rpt_cnt_q   <= '0;
      hold_idx_q  <= '0;
      dir_dec_q   <= 1'b0;
      clr_prev_q  <= 1'b0;
      inc_pulse_q <= '0;
      dec_pulse_q <= '0;
      for (int unsigned i = 0; i < NUM_ADJ; i++) begin
        level_q[i]   <= '0;
        lvl_out_q[i] <= '0;
      end
    end else begin
      match_q     <= match_d;
      frame_en_q  <= frame_en_d;
      wr_en_q     <= wr_en_d;
      shift_en_q  <= shift_en_d;
      sync1_q     <= KEY[2:0];
      sync2_q     <= sync1_q;
      deb_q       <= deb_d;
      deb_cnt_q   <= deb_cnt_d;
      sel_idx_q   <= sel_idx_d;
      sel_valid_q <= sel_valid_d;
      state_q     <= state_d;
      rpt_cnt_q   <= rpt_cnt_d;
      hold_idx_q  <= hold_idx_d;
      dir_dec_q   <= dir_dec_d;
      clr_prev_q  <= deb_q[2];
      inc_pulse_q <= inc_pulse_d;
      dec_pulse_q <= dec_pulse_d;
      for (int unsigned i = 0; i < NUM_ADJ; i++) begin
        level_q[i]   <= level_d[i];
        lvl_out_q[i] <= lvl_out_d[i];
      end
    end
  end

endmodule

// File: tb/tb_adj_control.sv
// Scoreboard bench for adj_control: stimulus pushes expected pulses/commits, a negedge monitor checks them.
module tb_adj_control;
  localparam int NA = 4;
  localparam int LW = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic [9:0]      SW;
  logic [3:0]      KEY;
  logic [12:0]     row, col, x_count, y_count;
  logic            frame_en, wr_en, shift_en, sel_valid;
  logic [NA-1:0]   inc_pulse, dec_pulse;
  logic [NA*LW-1:0] level_out;

  adj_control #(
    .NUM_ADJ(NA), .LVL_W(LW), .LVL_LIM(127), .STEP(4),
    .DEB_CYC(2), .REPEAT_DLY(8), .REPEAT_RATE(4)
  ) dut (
    .clk(clk), .rst(rst), .SW(SW), .KEY(KEY),
    .row(row), .col(col), .x_count(x_count), .y_count(y_count),
    .frame_en(frame_en), .wr_en(wr_en), .shift_en(shift_en), .sel_valid(sel_valid),
    .inc_pulse(inc_pulse), .dec_pulse(dec_pulse), .level_out(level_out)
  );

  always #5 clk = ~clk;

`ifdef AUTOREPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  typedef struct packed {
    logic [NA-1:0] inc;
    logic [NA-1:0] dec;
  } pulse_t;

  int               n_chk = 0;
  int               n_fail = 0;
  int               lvl [NA];
  pulse_t           exp_pulse [$];
  logic [NA*LW-1:0] exp_frame [$];
  logic [NA*LW-1:0] pend_lvl;
  bit               pend_v = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops expectations whenever the DUT presents a pulse or a frame commit
  always @(negedge clk) begin
    pulse_t e;
    if (pend_v) begin
      check("level_out_commit", 64'(level_out), 64'(pend_lvl));
      pend_v = 1'b0;
    end
    if (!rst && frame_en) begin
      check("frame_en_expected", 64'(exp_frame.size() != 0), 64'd1);
      if (exp_frame.size() != 0) begin
        pend_lvl = exp_frame.pop_front();
        pend_v   = 1'b1;
      end
    end
    if ((inc_pulse | dec_pulse) != '0) begin
      if (exp_pulse.size() != 0) begin
        e = exp_pulse.pop_front();
        check("pulse", 64'({inc_pulse, dec_pulse}), 64'(e));
      end else begin
        check("pulse_unexpected", 64'({inc_pulse, dec_pulse}), 64'd0);
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press(input logic [3:0] m, input int hold);
    KEY = ~m;
    tick(hold);
    KEY = 4'hF;
    tick(6);
  endtask

  task automatic model_ev(input int ch, input bit dn);
    pulse_t e;
    e = '0;
    if (dn) begin
      e.dec[ch] = 1'b1;
      lvl[ch] = (lvl[ch] - 4 < -127) ? -127 : lvl[ch] - 4;
    end else begin
      e.inc[ch] = 1'b1;
      lvl[ch] = (lvl[ch] + 4 > 127) ? 127 : lvl[ch] + 4;
    end
    exp_pulse.push_back(e);
  endtask

  task automatic do_frame();
    logic [NA*LW-1:0] v;
    int               t;
    for (int i = 0; i < NA; i++) begin
      t = lvl[i];
      v[i*LW +: LW] = t[LW-1:0];
    end
    exp_frame.push_back(v);
    row = 13'd480;
    col = 13'd640;
    tick(3);
    col = 13'd0;
    row = 13'd0;
    tick(3);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_frame_en"}, 64'(frame_en), 64'd0);
    check({tag, "_wr_en"}, 64'(wr_en), 64'd0);
    check({tag, "_shift_en"}, 64'(shift_en), 64'd0);
    check({tag, "_sel_valid"}, 64'(sel_valid), 64'd0);
    check({tag, "_pulses"}, 64'({inc_pulse, dec_pulse}), 64'd0);
    check({tag, "_level_out"}, 64'(level_out), 64'd0);
  endtask

  initial begin
    rst = 1'b1; SW = '0; KEY = 4'hF;
    row = '0; col = '0; x_count = '0; y_count = '0;
    for (int i = 0; i < NA; i++) lvl[i] = 0;
    tick(2);
    check_all_zero("reset");
    rst = 1'b0;
    tick(2);
    check("sel_none", 64'(sel_valid), 64'd0);

    // 1. Raster enables and a zero commit
    do_frame();
    col = 13'd639; tick(); check("wr_en_639", 64'(wr_en), 64'd1);
    col = 13'd640; tick(); check("wr_en_640", 64'(wr_en), 64'd0);
    col = 13'd0;
    x_count = 13'd781; y_count = 13'd527; tick(); check("shift_en_527", 64'(shift_en), 64'd1);
    y_count = 13'd528; tick(); check("shift_en_528", 64'(shift_en), 64'd0);
    x_count = 13'd0; y_count = 13'd0; tick();

    // 2. Single press on channel 0
    SW = 10'b00_0000_0010; tick(2);
    check("sel_ch0", 64'(sel_valid), 64'd1);
    model_ev(0, 1'b0);
    press(4'b0001, 6);
    do_frame();

    // 3. Hold dec on channel 2: events at entry, +8, +12, +16, +20, +24
    SW = 10'b00_0000_1000; tick(2);
    for (int i = 0; i < (AR ? 6 : 1); i++) model_ev(2, 1'b1);
    press(4'b0010, 27);
    do_frame();

    // 4. Saturation, clear, clear-with-inc
    SW = 10'b00_0000_0100; tick(2);
    for (int i = 0; i < 40; i++) begin
      model_ev(1, 1'b0);
      press(4'b0001, 6);
    end
    do_frame();
    press(4'b0100, 6);
    lvl[1] = 0;
    model_ev(1, 1'b0);
    press(4'b0001, 6);
    press(4'b0101, 6);
    lvl[1] = 0;
    do_frame();

    // 5. Invalid selections and both keys pressed
    SW = 10'b00_0000_0110; tick(2);
    check("sel_two", 64'(sel_valid), 64'd0);
    press(4'b0001, 6);
    SW = 10'b00_0000_0000; tick(2);
    check("sel_zero", 64'(sel_valid), 64'd0);
    press(4'b0001, 6);
    SW = 10'b00_0000_0010; tick(2);
    press(4'b0011, 6);
    do_frame();

    // 6. Reset while repeating, key still held afterwards
    for (int i = 0; i < (AR ? 3 : 1); i++) model_ev(0, 1'b0);
    KEY = 4'b1110;
    tick(18);
    rst = 1'b1;
    tick();
    check_all_zero("midrst");
    rst = 1'b0;
    for (int i = 0; i < NA; i++) lvl[i] = 0;
    model_ev(0, 1'b0);
    tick(7);
    KEY = 4'hF;
    tick(6);
    do_frame();

    tick(5);
    check("pulse_queue_drained", 64'(exp_pulse.size()), 64'd0);
    check("frame_queue_drained", 64'(exp_frame.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
